// File: rtl/psram_bus_arb.sv
// Round-robin arbiter and sequencer for the shared QSPI PSRAM bus.
// Caps each grant at MAX_BEATS and spaces transfers by GAP_CYC idle cycles.
module psram_bus_arb #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = 32,
  parameter int GAP_CYC   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       start_o,
  input  logic                       beat_i,
  output logic                       brk_o,
  input  logic                       done_i,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [CW-1:0] CMAX  = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CSAT  = '1;
  localparam logic [GW-1:0] GLOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IW-1:0] ILAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BREAK,
    S_GAP
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [GW-1:0]        gap_q;
  logic                 start_q;
  logic                 brk_q;
  logic                 busy_q;
  logic                 sel_vld;
  logic [IW-1:0]        sel_idx;
  logic                 hit_max;

  // Walk downward so the smallest offset from the pointer wins.
  always_comb begin
    sel_vld = |req_i;
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        sel_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (beat_i && cnt_q != CSAT) begin
      cnt_d = cnt_q + 1'b1;
    end
    hit_max = (MAX_BEATS != 0) && (cnt_d == CMAX);
    ptr_d   = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      brk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            state_q <= S_GRANT;
            gnt_q   <= NUM_REQ'(1) << sel_idx;
            idx_q   <= sel_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_GRANT, S_BREAK: begin
          if (state_q == S_GRANT) begin
            cnt_q <= cnt_d;
          end
          if (done_i) begin
            gnt_q   <= '0;
            brk_q   <= 1'b0;
            ptr_q   <= ptr_d;
            gap_q   <= GLOAD;
            state_q <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
            busy_q  <= (GAP_CYC != 0);
          end else if (state_q == S_GRANT && hit_max) begin
            state_q <= S_BREAK;
            brk_q   <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign start_o   = start_q;
  assign brk_o     = brk_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_psram_bus_arb.sv
// Directed bench for psram_bus_arb: one instance with MAX_BEATS=32,
// a second with MAX_BEATS=4, both driven by the same stimulus.
module tb_psram_bus_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       beat;
  logic       done;

  logic [1:0] a_gnt, b_gnt;
  logic       a_idx, b_idx;
  logic       a_start, b_start;
  logic       a_brk, b_brk;
  logic       a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psram_bus_arb #(
    .NUM_REQ(2), .MAX_BEATS(32), .GAP_CYC(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
    .gnt_o(a_gnt), .gnt_idx_o(a_idx), .start_o(a_start),
    .beat_i(beat), .brk_o(a_brk), .done_i(done),
    .busy_o(a_busy)
  );

  psram_bus_arb #(
    .NUM_REQ(2), .MAX_BEATS(4), .GAP_CYC(2)
  ) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
    .gnt_o(b_gnt), .gnt_idx_o(b_idx), .start_o(b_start),
    .beat_i(beat), .brk_o(b_brk), .done_i(done),
    .busy_o(b_busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    beat  = 1'b0;
    done  = 1'b0;
    tick(2);
    chk("rst_gnt",   32'(a_gnt),   32'h0);
    chk("rst_idx",   32'(a_idx),   32'h0);
    chk("rst_start", 32'(a_start), 32'h0);
    chk("rst_brk",   32'(a_brk),   32'h0);
    chk("rst_busy",  32'(a_busy),  32'h0);
    rst_n = 1'b1;

    // T1 single transfer
    req = 2'b01;
    tick();
    chk("t1_gnt",   32'(a_gnt),   32'h1);
    chk("t1_start", 32'(a_start), 32'h1);
    chk("t1_busy",  32'(a_busy),  32'h1);
    req = 2'b00;
    tick();
    chk("t1_start_pulse", 32'(a_start), 32'h0);
    chk("t1_gnt_hold",    32'(a_gnt),   32'h1);
    for (int i = 0; i < 5; i++) begin
      beat = 1'b1;
      tick();
    end
    beat = 1'b0;
    chk("t1_nobrk",    32'(a_brk), 32'h0);
    chk("t1_brk_max4", 32'(b_brk), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t1_gnt_off", 32'(a_gnt),  32'h0);
    chk("t1_gap1",    32'(a_busy), 32'h1);
    chk("t1_brk4off", 32'(b_brk),  32'h0);
    tick();
    chk("t1_gap2", 32'(a_busy), 32'h1);
    tick();
    chk("t1_idle", 32'(a_busy), 32'h0);

    // T2 fairness, starting from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("t2_idx%0d", t), 32'(a_idx), 32'(t % 2));
      chk($sformatf("t2_gnt%0d", t), 32'(a_gnt),
          32'(1 << (t % 2)));
      for (int i = 0; i < 3; i++) begin
        beat = 1'b1;
        tick();
      end
      beat = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk($sformatf("t2_off%0d", t), 32'(a_gnt), 32'h0);
      tick(2);
    end
    req = 2'b00;
    tick();
    chk("t2_idle", 32'(a_busy), 32'h0);

    // T3 forced break on the MAX_BEATS=4 instance
    req = 2'b11;
    tick();
    chk("t3_gnt0", 32'(b_gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1;
      tick();
    end
    chk("t3_brk_early", 32'(b_brk), 32'h0);
    tick();
    beat = 1'b0;
    chk("t3_brk_on", 32'(b_brk), 32'h1);
    chk("t3_a_nobrk", 32'(a_brk), 32'h0);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    chk("t3_brk_hold", 32'(b_brk), 32'h1);
    chk("t3_gnt_hold", 32'(b_gnt), 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t3_brk_off", 32'(b_brk), 32'h0);
    chk("t3_gnt_off", 32'(b_gnt), 32'h0);
    tick(2);
    tick();
    chk("t3_next_idx", 32'(b_idx), 32'h1);
    chk("t3_next_gnt", 32'(b_gnt), 32'h2);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick(2);

    // T4 done together with the 4th beat
    tick();
    chk("t4_gnt0", 32'(b_gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1;
      tick();
    end
    done = 1'b1;
    tick();
    beat = 1'b0;
    done = 1'b0;
    chk("t4_nobrk", 32'(b_brk),  32'h0);
    chk("t4_gnt",   32'(b_gnt),  32'h0);
    chk("t4_gap",   32'(b_busy), 32'h1);
    tick();
    chk("t4_nobrk2", 32'(b_brk), 32'h0);
    tick();

    // T5 reset while in BREAK
    tick();
    chk("t5_gnt1", 32'(b_gnt), 32'h2);
    for (int i = 0; i < 4; i++) begin
      beat = 1'b1;
      tick();
    end
    beat = 1'b0;
    chk("t5_brk", 32'(b_brk), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_gnt",  32'(b_gnt),  32'h0);
    chk("t5_brk0", 32'(b_brk),  32'h0);
    chk("t5_busy", 32'(b_busy), 32'h0);
    chk("t5_idx",  32'(b_idx),  32'h0);
    tick();
    chk("t5_regnt", 32'(b_gnt), 32'h1);

    // T6 request rising during the gap
    req  = 2'b00;
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 2'b10;
    chk("t6_gap_e0", 32'(a_gnt), 32'h0);
    tick();
    chk("t6_gap_e1", 32'(a_gnt), 32'h0);
    tick();
    chk("t6_gap_e2", 32'(a_gnt), 32'h0);
    tick();
    chk("t6_gnt",   32'(a_gnt),   32'h2);
    chk("t6_start", 32'(a_start), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
